ec_prod_sum_seq: RTL and testbench

Fast-clock batch sequencer sitting directly upstream of the error-correcting RNS product-sum core. Generates the per-batch `data_in_rd_req` / `trunc_ena` / `clear_ena` pattern that pops operand residues from the A/B input FIFOs and frames each NUM_PRODS-term dot product. Gates every batch on input-FIFO occupancy and result-FIFO space, counts batches, and reports completion.

---
 rtl/ec_prod_sum_pkg.sv | 23 ++
 rtl/ec_seq_phase_decode.sv | 31 +++
 rtl/ec_prod_sum_seq.sv | 155 +++++++++++++++
 tb/tb_ec_prod_sum_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ec_prod_sum_pkg.sv
// ec_prod_sum_pkg: shared types and phase constants for the product-sum
// batch sequencer (state encoding, trunc window, clear phase offset).
package ec_prod_sum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ec_seq_state_t;

  // trunc is high for TRUNC_START <= c <= NUM_PRODS - TRUNC_END_OFS
  localparam int unsigned TRUNC_START   = 2;
  localparam int unsigned TRUNC_END_OFS = 4;
  // clear pulses at c = NUM_PRODS - CLEAR_OFS
  localparam int unsigned CLEAR_OFS     = 1;

  // Phase counter must hold 0..num_prods inclusive.
  function automatic int unsigned phase_width(input int unsigned num_prods);
    return $clog2(num_prods + 1);
  endfunction

endpackage

// File: rtl/ec_seq_phase_decode.sv
// ec_seq_phase_decode: combinational map from RUN phase c to the
// rd/trunc/clear levels the core expects for that phase.
// Ports:
//   phase   - RUN phase counter value (0..NUM_PRODS)
//   rd_c    - FIFO pop for this phase
//   trunc_c - core truncation enable for this phase
//   clear_c - accumulator clear for this phase
module ec_seq_phase_decode
  import ec_prod_sum_pkg::*;
#(
  parameter int unsigned NUM_PRODS = 16,
  parameter int unsigned PHASE_W   = phase_width(NUM_PRODS)
) (
  input  logic [PHASE_W-1:0] phase,
  output logic               rd_c,
  output logic               trunc_c,
  output logic               clear_c
);

  localparam logic [PHASE_W-1:0] RD_END    = PHASE_W'(NUM_PRODS);
  localparam logic [PHASE_W-1:0] TR_FIRST  = PHASE_W'(TRUNC_START);
  localparam logic [PHASE_W-1:0] TR_LAST   = PHASE_W'(NUM_PRODS - TRUNC_END_OFS);
  localparam logic [PHASE_W-1:0] CLR_PHASE = PHASE_W'(NUM_PRODS - CLEAR_OFS);

  always_comb begin
    rd_c    = (phase < RD_END);
    trunc_c = (phase >= TR_FIRST) && (phase <= TR_LAST);
    clear_c = (phase == CLR_PHASE);
  end

endmodule

// File: rtl/ec_prod_sum_seq.sv
// ec_prod_sum_seq: fast-clock batch sequencer feeding the RNS product-sum
// core. Frames each NUM_PRODS-term dot product with rd/trunc/clear, gates
// batches on FIFO occupancy/space, counts batches, pulses done at the end.
// Optional feature macro: EC_PROD_SUM_SEQ_GATE_EN (occupancy/full gating of
// WAIT->RUN; when undefined WAIT always lasts exactly one cycle).
// Ports:
//   f_clk, f_rst_n         - clock, async active-low reset
//   start, num_batches     - run request and batch count (sampled in IDLE)
//   abort                  - synchronous return to IDLE
//   data_A/B_rd_used       - input FIFO occupancies
//   result_wr_full         - result FIFO full
//   data_in_rd_req, trunc_ena, clear_ena - core/FIFO controls (registered)
//   busy, done, batch_cnt  - status (registered)
module ec_prod_sum_seq
  import ec_prod_sum_pkg::*;
#(
  parameter int unsigned NUM_PRODS = 16,
  parameter int unsigned USED_W    = 9,
  parameter int unsigned BATCH_W   = 8
) (
  input  logic               f_clk,
  input  logic               f_rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [BATCH_W-1:0] num_batches,
  input  logic [USED_W-1:0]  data_A_rd_used,
  input  logic [USED_W-1:0]  data_B_rd_used,
  input  logic               result_wr_full,
  output logic               data_in_rd_req,
  output logic               trunc_ena,
  output logic               clear_ena,
  output logic               busy,
  output logic               done,
  output logic [BATCH_W-1:0] batch_cnt
);

  localparam int unsigned        PHASE_W    = phase_width(NUM_PRODS);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PRODS);

  ec_seq_state_t      state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [BATCH_W-1:0] nb_q, nb_d, bcnt_d, bcnt_inc;
  logic               gate_ok;
  logic               dec_rd_c, dec_trunc_c, dec_clear_c;
  logic               rd_d, trunc_d, clear_d, busy_d, done_d;

  // WAIT exit qualifier
`ifdef EC_PROD_SUM_SEQ_GATE_EN
  assign gate_ok = (data_A_rd_used >= USED_W'(NUM_PRODS)) &&
                   (data_B_rd_used >= USED_W'(NUM_PRODS)) &&
                   !result_wr_full;
`else
  logic unused_gate_inputs;
  assign unused_gate_inputs = ^{data_A_rd_used, data_B_rd_used, result_wr_full};
  assign gate_ok = 1'b1;
`endif

  assign bcnt_inc = batch_cnt + BATCH_W'(1);

  // Next state, phase and counters; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    nb_d    = nb_q;
    bcnt_d  = batch_cnt;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nb_d    = num_batches;
          bcnt_d  = '0;
          phase_d = '0;
          state_d = (num_batches == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (gate_ok) begin
          state_d = ST_RUN;
          phase_d = '0;
        end
      end
      ST_RUN: begin
        if (phase_q == PHASE_LAST) begin
          bcnt_d  = bcnt_inc;
          phase_d = '0;
          state_d = (bcnt_inc == nb_q) ? ST_DONE : ST_WAIT;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      phase_d = '0;
      nb_d    = nb_q;
      bcnt_d  = batch_cnt;
    end
  end

  // Decode is applied to the phase being entered so outputs line up with it.
  ec_seq_phase_decode #(
    .NUM_PRODS (NUM_PRODS),
    .PHASE_W   (PHASE_W)
  ) u_phase_decode (
    .phase   (phase_d),
    .rd_c    (dec_rd_c),
    .trunc_c (dec_trunc_c),
    .clear_c (dec_clear_c)
  );

  // Output values for the state being entered
  always_comb begin
    rd_d    = 1'b0;
    trunc_d = 1'b0;
    clear_d = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    case (state_d)
      ST_RUN: begin
        rd_d    = dec_rd_c;
        trunc_d = dec_trunc_c;
        clear_d = dec_clear_c;
      end
      ST_IDLE, ST_DONE: clear_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge f_clk or negedge f_rst_n) begin
    if (!f_rst_n) begin
      state_q        <= ST_IDLE;
      phase_q        <= '0;
      nb_q           <= '0;
      batch_cnt      <= '0;
      data_in_rd_req <= 1'b0;
      trunc_ena      <= 1'b0;
      clear_ena      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      nb_q           <= nb_d;
      batch_cnt      <= bcnt_d;
      data_in_rd_req <= rd_d;
      trunc_ena      <= trunc_d;
      clear_ena      <= clear_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

endmodule

// File: tb/tb_ec_prod_sum_seq.sv
// tb_ec_prod_sum_seq: scoreboard bench for ec_prod_sum_seq. Expected batch
// and done records are queued when a run is issued; a monitor rebuilds each
// batch from the rd/trunc/clear waveform and checks it against the queue.
module tb_ec_prod_sum_seq;

  localparam int N       = 16;
  localparam int USED_W  = 9;
  localparam int BATCH_W = 8;
  localparam int LIMIT   = 2000;

  logic               f_clk = 1'b0;
  logic               f_rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [BATCH_W-1:0] num_batches = '0;
  logic [USED_W-1:0]  data_A_rd_used = USED_W'(N);
  logic [USED_W-1:0]  data_B_rd_used = USED_W'(N);
  logic               result_wr_full = 1'b0;
  logic               data_in_rd_req, trunc_ena, clear_ena, busy, done;
  logic [BATCH_W-1:0] batch_cnt;

  ec_prod_sum_seq #(
    .NUM_PRODS (N),
    .USED_W    (USED_W),
    .BATCH_W   (BATCH_W)
  ) dut (
    .f_clk          (f_clk),
    .f_rst_n        (f_rst_n),
    .start          (start),
    .abort          (abort),
    .num_batches    (num_batches),
    .data_A_rd_used (data_A_rd_used),
    .data_B_rd_used (data_B_rd_used),
    .result_wr_full (result_wr_full),
    .data_in_rd_req (data_in_rd_req),
    .trunc_ena      (trunc_ena),
    .clear_ena      (clear_ena),
    .busy           (busy),
    .done           (done),
    .batch_cnt      (batch_cnt)
  );

  always #5 f_clk = ~f_clk;

  typedef struct {
    bit is_done;
    int rd_len;
    int trunc_cnt;
    int trunc_first;
    int clear_cnt;
    int clear_pos;
    int end_trunc;
    int end_clear;
    int gap;
    int bcnt;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  always @(posedge f_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic flag(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d with no matching expectation (cycle %0d)", name, act, cyc);
  endtask

  // Reference batch: walk phases 0..last_rd_c through the phase rules.
  // cut = batch ended early (abort/reset), so the following cycle is IDLE-like.
  function automatic exp_t model_batch(input int last_rd_c, input bit cut, input int gap);
    exp_t e;
    e = '{default: 0};
    e.trunc_first = -1;
    e.clear_pos   = -1;
    e.gap         = gap;
    e.bcnt        = -1;
    e.lat         = -1;
    for (int c = 0; c <= last_rd_c; c++) begin
      if (c < N) begin
        e.rd_len++;
        if (c >= 2 && c <= N - 4) begin
          if (e.trunc_first < 0) e.trunc_first = c;
          e.trunc_cnt++;
        end
        if (c == N - 1) begin
          e.clear_cnt++;
          e.clear_pos = c;
        end
      end
    end
    e.end_trunc = 0;
    e.end_clear = cut ? 1 : 0;
    return e;
  endfunction

  function automatic exp_t model_done(input int nb, input int lat);
    exp_t e;
    e = '{default: 0};
    e.is_done = 1'b1;
    e.bcnt    = nb;
    e.lat     = lat;
    e.gap     = -1;
    return e;
  endfunction

  // Monitor: reconstruct batches and done pulses, compare with queue head.
  int   m_len, m_tc, m_tf, m_cc, m_cp, m_gap, last_rise;
  bit   have_rise = 1'b0;
  bit   rd_prev = 1'b0;
  bit   done_prev = 1'b0;
  exp_t m_e;

  always @(negedge f_clk) begin
    if (done_prev) chk("done_one_cycle", int'(done), 0);
    if (data_in_rd_req === 1'b1 && !rd_prev) begin
      m_len = 0; m_tc = 0; m_tf = -1; m_cc = 0; m_cp = -1;
      m_gap = have_rise ? (cyc - last_rise) : -1;
      last_rise = cyc;
      have_rise = 1'b1;
    end
    if (data_in_rd_req === 1'b1) begin
      if (trunc_ena === 1'b1) begin
        if (m_tf < 0) m_tf = m_len;
        m_tc++;
      end
      if (clear_ena === 1'b1) begin
        m_cc++;
        m_cp = m_len;
      end
      m_len++;
    end
    if (data_in_rd_req === 1'b0 && rd_prev) begin
      if (sb_q.size() == 0 || sb_q[0].is_done) begin
        flag("unexpected_batch", m_len);
      end else begin
        m_e = sb_q.pop_front();
        chk("batch_rd_len", m_len, m_e.rd_len);
        chk("batch_trunc_cnt", m_tc, m_e.trunc_cnt);
        chk("batch_trunc_first", m_tf, m_e.trunc_first);
        chk("batch_clear_cnt", m_cc, m_e.clear_cnt);
        chk("batch_clear_pos", m_cp, m_e.clear_pos);
        chk("batch_end_trunc", int'(trunc_ena), m_e.end_trunc);
        chk("batch_end_clear", int'(clear_ena), m_e.end_clear);
        if (m_e.gap >= 0) chk("batch_gap", m_gap, m_e.gap);
      end
    end
    if (done === 1'b1) begin
      if (sb_q.size() == 0 || !sb_q[0].is_done) begin
        flag("unexpected_done", int'(batch_cnt));
      end else begin
        m_e = sb_q.pop_front();
        chk("done_batch_cnt", int'(batch_cnt), m_e.bcnt);
        if (m_e.lat >= 0) chk("done_latency", cyc - start_cyc, m_e.lat);
        chk("done_rd", int'(data_in_rd_req), 0);
        chk("done_clear", int'(clear_ena), 1);
        chk("done_busy", int'(busy), 1);
      end
    end
    rd_prev   = (data_in_rd_req === 1'b1);
    done_prev = (done === 1'b1);
  end

  task automatic tick();
    @(posedge f_clk);
    #1;
  endtask

  // Queue a full run; timed = FIFOs pre-filled, so spacing is exact.
  task automatic push_run(input int nb, input bit timed);
    for (int b = 0; b < nb; b++)
      sb_q.push_back(model_batch(N - 1, 1'b0, (b == 0 || !timed) ? -1 : N + 2));
    sb_q.push_back(model_done(nb, timed ? nb * (N + 2) : -1));
  endtask

  task automatic issue_start(input int nb);
    start       = 1'b1;
    num_batches = BATCH_W'(nb);
    tick();
    start     = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_idle(input bit poke);
    int t;
    t = 0;
    while (busy === 1'b1 && t < LIMIT) begin
      if (poke && $urandom_range(0, 5) == 0) begin
        start       = 1'b1;
        num_batches = BATCH_W'($urandom_range(0, 255));
      end
      tick();
      start = 1'b0;
      t++;
    end
    chk("idle_after_run", int'(busy), 0);
  endtask

  task automatic wait_rises(input int want, output int got);
    int  t;
    bit  prev;
    got  = 0;
    t    = 0;
    prev = (data_in_rd_req === 1'b1);
    while (got < want && t < LIMIT) begin
      tick();
      if (data_in_rd_req === 1'b1 && !prev) got++;
      prev = (data_in_rd_req === 1'b1);
      t++;
    end
  endtask

  initial begin
    int rises;
    int nb;

    // Reset values
    tick();
    tick();
    chk("rst_rd", int'(data_in_rd_req), 0);
    chk("rst_trunc", int'(trunc_ena), 0);
    chk("rst_clear", int'(clear_ena), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_batch_cnt", int'(batch_cnt), 0);
    f_rst_n = 1'b1;
    tick();

    // Single batch
    push_run(1, 1'b1);
    issue_start(1);
    wait_idle(1'b0);
    chk("single_batch_cnt", int'(batch_cnt), 1);

    // Three batches back to back, start pokes while busy
    tick();
    push_run(3, 1'b1);
    issue_start(3);
    wait_idle(1'b1);
    chk("three_batch_cnt", int'(batch_cnt), 3);

    // Zero batches: immediate done, no reads
    tick();
    push_run(0, 1'b1);
    issue_start(0);
    chk("zero_rd", int'(data_in_rd_req), 0);
    wait_idle(1'b0);
    chk("zero_batch_cnt", int'(batch_cnt), 0);

`ifdef EC_PROD_SUM_SEQ_GATE_EN
    // A-FIFO short by one word holds WAIT
    tick();
    data_A_rd_used = USED_W'(N - 1);
    push_run(1, 1'b0);
    issue_start(1);
    repeat (10) begin
      tick();
      chk("gate_a_hold_rd", int'(data_in_rd_req), 0);
    end
    data_A_rd_used = USED_W'(N);
    tick();
    chk("gate_a_release_rd", int'(data_in_rd_req), 1);
    wait_idle(1'b0);

    // Result FIFO full holds WAIT
    tick();
    result_wr_full = 1'b1;
    push_run(1, 1'b0);
    issue_start(1);
    repeat (10) begin
      tick();
      chk("gate_full_hold_rd", int'(data_in_rd_req), 0);
    end
    result_wr_full = 1'b0;
    tick();
    chk("gate_full_release_rd", int'(data_in_rd_req), 1);
    wait_idle(1'b0);
`endif

    // Abort at phase 7 of batch 2
    tick();
    sb_q.push_back(model_batch(N - 1, 1'b0, -1));
    sb_q.push_back(model_batch(7, 1'b1, N + 2));
    issue_start(3);
    wait_rises(2, rises);
    chk("abort_reach_batch2", rises, 2);
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rd", int'(data_in_rd_req), 0);
    chk("abort_clear", int'(clear_ena), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_batch_cnt", int'(batch_cnt), 1);

    // start and abort together: abort wins, count untouched
    start       = 1'b1;
    abort       = 1'b1;
    num_batches = BATCH_W'(2);
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_batch_cnt", int'(batch_cnt), 1);

    // Randomized runs with random idle gaps and ignored start pokes
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 3)) tick();
      nb = int'($urandom_range(0, 4));
      push_run(nb, 1'b1);
      issue_start(nb);
      wait_idle(1'b1);
      chk("rand_batch_cnt", int'(batch_cnt), nb);
    end

    // Reset in the middle of RUN (phase 4 of batch 1)
    tick();
    sb_q.push_back(model_batch(3, 1'b1, -1));
    issue_start(2);
    wait_rises(1, rises);
    chk("reset_reach_run", rises, 1);
    repeat (4) tick();
    f_rst_n = 1'b0;
    #1;
    chk("midrst_rd", int'(data_in_rd_req), 0);
    chk("midrst_trunc", int'(trunc_ena), 0);
    chk("midrst_clear", int'(clear_ena), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_batch_cnt", int'(batch_cnt), 0);
    tick();
    tick();
    f_rst_n = 1'b1;
    tick();
    tick();
    chk("post_reset_busy", int'(busy), 0);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
